// File: rtl/sbb_mac_seq.sv
// Sequential radix-4 multiply-accumulate unit with valid/ready handshakes.
// Each operand may be signed or unsigned; the accumulator wraps or saturates depending on SAT.
module sbb_mac_seq #(
  parameter int W     = 8,
  parameter int ACC_W = 24,
  parameter bit SAT   = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic             sa,
  input  logic             sb,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc,
  output logic             ovf,
  output logic             busy
);

  localparam int ND = W / 2;
  localparam int CW = (ND > 1) ? $clog2(ND) : 1;
  localparam int PW = 2 * W + 2;

  typedef enum logic [1:0] {IDLE, MUL, ACC, HOLD} state_t;

  state_t              state;
  logic [W-1:0]        a_q;
  logic [W-1:0]        b_q;
  logic                sa_q;
  logic                sb_q;
  logic                clr_q;
  logic [CW-1:0]       cnt;
  logic signed [PW-1:0] pp;

  logic                 last_digit;
  logic [W-1:0]         b_sh;
  logic [1:0]           dig;
  logic signed [PW-1:0] a_wide;
  logic signed [PW-1:0] d_wide;
  logic signed [PW-1:0] term;

  logic signed [ACC_W:0] acc_base;
  logic signed [ACC_W:0] sum;
  logic                  ovf_now;
  logic [ACC_W-1:0]      acc_next;

  // Extending a straight to PW bits is equivalent to the W+2-bit extension
  // followed by the PW-bit partial-product arithmetic.
  always_comb begin
    last_digit = (cnt == CW'(ND - 1));
    b_sh       = b_q >> (2 * cnt);
    dig        = b_sh[1:0];
    a_wide     = sa_q ? PW'($signed(a_q)) : PW'(a_q);
    d_wide     = (last_digit && sb_q) ? PW'($signed(dig)) : PW'(dig);
    term       = (a_wide * d_wide) <<< (2 * cnt);
  end

  always_comb begin
    acc_base = clr_q ? '0 : {acc[ACC_W-1], acc};
    sum      = acc_base + (ACC_W + 1)'(pp);
    ovf_now  = sum[ACC_W] ^ sum[ACC_W-1];
    acc_next = sum[ACC_W-1:0];
    if (ovf_now && SAT) begin
      acc_next = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      sa_q      <= 1'b0;
      sb_q      <= 1'b0;
      clr_q     <= 1'b0;
      cnt       <= '0;
      pp        <= '0;
      acc       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b;
            sa_q     <= sa;
            sb_q     <= sb;
            clr_q    <= acc_clr;
            cnt      <= '0;
            pp       <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= MUL;
          end
        end
        MUL: begin
          pp <= pp + term;
          if (last_digit) begin
            cnt   <= '0;
            state <= ACC;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ACC: begin
          acc       <= acc_next;
          ovf       <= (clr_q ? 1'b0 : ovf) | ovf_now;
          out_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sbb_mac_seq.sv
// Scoreboard bench for sbb_mac_seq: one default instance plus two 17-bit accumulator
// instances (saturating and wrapping) driven in lockstep.
module tb_sbb_mac_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic sa = 1'b0;
  logic sb = 1'b0;
  logic acc_clr = 1'b0;

  logic        in_ready0, out_valid0, ovf0, busy0;
  logic [23:0] acc0;
  logic        in_ready1, out_valid1, ovf1, busy1;
  logic [16:0] acc1;
  logic        in_ready2, out_valid2, ovf2, busy2;
  logic [16:0] acc2;

  always #5 clk = ~clk;

  sbb_mac_seq #(.W(8), .ACC_W(24), .SAT(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .a(a), .b(b), .sa(sa), .sb(sb), .acc_clr(acc_clr),
    .out_valid(out_valid0), .out_ready(out_ready), .acc(acc0), .ovf(ovf0), .busy(busy0));

  sbb_mac_seq #(.W(8), .ACC_W(17), .SAT(1'b1)) u_sat17 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .a(a), .b(b), .sa(sa), .sb(sb), .acc_clr(acc_clr),
    .out_valid(out_valid1), .out_ready(out_ready), .acc(acc1), .ovf(ovf1), .busy(busy1));

  sbb_mac_seq #(.W(8), .ACC_W(17), .SAT(1'b0)) u_wrap17 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .a(a), .b(b), .sa(sa), .sb(sb), .acc_clr(acc_clr),
    .out_valid(out_valid2), .out_ready(out_ready), .acc(acc2), .ovf(ovf2), .busy(busy2));

  typedef struct {
    longint e0, e1, e2;
    bit     o0, o1, o2;
  } exp_t;

  exp_t   sb_q[$];
  int     total = 0;
  int     bad = 0;
  longint m_acc[3] = '{0, 0, 0};
  bit     m_ovf[3] = '{0, 0, 0};
  int     cfg_w[3] = '{24, 17, 17};
  bit     cfg_s[3] = '{1'b1, 1'b1, 1'b0};

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint mac_model(input longint accv, input bit ovfv, input longint p,
                                       input bit clr, input int accw, input bit sat,
                                       output bit ovf_o);
    longint one = 64'sd1;
    longint hi  = (one <<< (accw - 1)) - 1;
    longint lo  = -(one <<< (accw - 1));
    longint s   = (clr ? 64'sd0 : accv) + p;
    longint r   = s;
    bit     of  = (s > hi) || (s < lo);
    if (of) begin
      if (sat) r = (s > 0) ? hi : lo;
      else begin
        r = s & ((one <<< accw) - 1);
        if (r > hi) r = r - (one <<< accw);
      end
    end
    ovf_o = (clr ? 1'b0 : ovfv) | of;
    return r;
  endfunction

  task automatic check_outputs(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
      return;
    end
    e = sb_q.pop_front();
    chk({tag, "_acc24"}, longint'($signed(acc0)), e.e0);
    chk({tag, "_ovf24"}, longint'(ovf0), longint'(e.o0));
    chk({tag, "_acc17s"}, longint'($signed(acc1)), e.e1);
    chk({tag, "_ovf17s"}, longint'(ovf1), longint'(e.o1));
    chk({tag, "_acc17w"}, longint'($signed(acc2)), e.e2);
    chk({tag, "_ovf17w"}, longint'(ovf2), longint'(e.o2));
  endtask

  // Runs one transaction; with hold=1 it returns while the result is still held.
  task automatic mac(input string tag, input bit [7:0] ta, input bit [7:0] tb,
                     input bit tsa, input bit tsb, input bit tclr, input bit hold);
    int     n;
    longint pa, pb, p;
    bit     o;
    exp_t   e;
    n = 0;
    @(negedge clk);
    while (!in_ready0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk({tag, "_in_ready_timeout"}, 0, 1);
    in_valid = 1'b1; a = ta; b = tb; sa = tsa; sb = tsb; acc_clr = tclr;
    out_ready = !hold;
    pa = tsa ? longint'($signed(ta)) : longint'(ta);
    pb = tsb ? longint'($signed(tb)) : longint'(tb);
    p  = pa * pb;
    for (int k = 0; k < 3; k++) begin
      m_acc[k] = mac_model(m_acc[k], m_ovf[k], p, tclr, cfg_w[k], cfg_s[k], o);
      m_ovf[k] = o;
    end
    e.e0 = m_acc[0]; e.e1 = m_acc[1]; e.e2 = m_acc[2];
    e.o0 = m_ovf[0]; e.o1 = m_ovf[1]; e.o2 = m_ovf[2];
    sb_q.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      #1 n++;
    end while (!out_valid0 && n < 20);
    chk({tag, "_latency"}, n, 5);
    chk({tag, "_busy"}, longint'(busy0), 1);
    check_outputs(tag);
    if (!hold) begin
      @(posedge clk);
      #1;
      chk({tag, "_ov_drop"}, longint'(out_valid0), 0);
      chk({tag, "_in_ready_back"}, longint'(in_ready0), 1);
    end
  endtask

  initial begin
    bit seen;
    #12;
    chk("rst_acc", longint'(acc0), 0);
    chk("rst_ovf", longint'(ovf0), 0);
    chk("rst_out_valid", longint'(out_valid0), 0);
    chk("rst_in_ready", longint'(in_ready0), 1);
    chk("rst_busy", longint'(busy0), 0);
    @(negedge clk) rst_n = 1'b1;

    mac("umax",     8'hFF, 8'hFF, 0, 0, 1, 0);
    mac("umax_acc", 8'hFF, 8'hFF, 0, 0, 0, 0);
    mac("one_clr",  8'h01, 8'h01, 0, 0, 1, 0);
    mac("ss_min",   8'h80, 8'h80, 1, 1, 1, 0);
    mac("ss_mix",   8'h80, 8'h7F, 1, 1, 0, 0);
    mac("su",       8'hFF, 8'hFF, 1, 0, 1, 0);
    mac("us",       8'hFF, 8'hFF, 0, 1, 1, 0);
    mac("ss",       8'hFF, 8'hFF, 1, 1, 1, 0);
    for (int i = 0; i < 6; i++)
      mac("rnd", 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), (i == 0), 0);

    mac("bp", 8'h12, 8'h34, 0, 1, 0, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'($urandom); a = 8'($urandom); b = 8'($urandom);
      sa = 1'($urandom); sb = 1'($urandom); acc_clr = 1'($urandom);
      @(posedge clk);
      #1;
      chk("bp_out_valid", longint'(out_valid0), 1);
      chk("bp_in_ready", longint'(in_ready0), 0);
      chk("bp_acc", longint'($signed(acc0)), m_acc[0]);
      chk("bp_ovf", longint'(ovf0), longint'(m_ovf[0]));
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_in_ready", longint'(in_ready0), 1);
    chk("bp_release_out_valid", longint'(out_valid0), 0);
    mac("after_bp", 8'h03, 8'h05, 0, 0, 0, 0);

    mac("pre_rst", 8'd10, 8'd10, 0, 0, 1, 0);
    @(negedge clk);
    in_valid = 1'b1; a = 8'd5; b = 8'd5; sa = 0; sb = 0; acc_clr = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_acc24", longint'(acc0), 0);
    chk("arst_acc17", longint'(acc1), 0);
    chk("arst_ovf", longint'(ovf0), 0);
    chk("arst_busy", longint'(busy0), 0);
    chk("arst_in_ready", longint'(in_ready0), 1);
    for (int k = 0; k < 3; k++) begin
      m_acc[k] = 0;
      m_ovf[k] = 1'b0;
    end
    @(negedge clk) rst_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1 if (out_valid0) seen = 1'b1;
    end
    chk("arst_no_out_valid", longint'(seen), 0);
    mac("post_rst", 8'h01, 8'h01, 0, 0, 0, 0);

    chk("sb_drained", longint'(sb_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
